// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, NOP encoding, register field positions
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT     = 2'd1,
        BUFFERED = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry pc/instr holding register. It catches a response that arrives while
// the pipeline is stalled.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // clear wins over load so that a redirect always empties the entry
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register. It keeps one request outstanding at a
// time, issues back-to-back on responses, and drops wrong-path responses after a redirect.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [4:0]      if_id_rs1,
    output logic [4:0]      if_id_rs2,
    output logic [1:0]      dbg_state
);

    // Handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready.
    // The address is held at fetch_pc until that edge. Each accepted request gets exactly
    // one in-order imem_resp_valid pulse. The response is never back-pressured.

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            accept;
    logic            resp_now;
    logic            buf_load;
    logic            buf_clear;
    logic            buf_valid;
    logic [XLEN-1:0] buf_pc;
    logic [XLEN-1:0] buf_instr;

    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && !redirect) begin
            case (state)
                FETCH:   imem_req_valid = 1'b1;
                WAIT:    imem_req_valid = imem_resp_valid && !stall;
                default: imem_req_valid = 1'b0;
            endcase
        end
    end

    assign imem_req_addr = fetch_pc;
    assign accept        = imem_req_valid && imem_req_ready;
    assign resp_now      = (state == WAIT) && imem_resp_valid;
    assign buf_load      = resp_now && stall && !redirect;
    assign buf_clear     = redirect || (state == BUFFERED && !stall);

    fetch_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (req_pc),
        .load_instr (imem_resp_data),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            if_id_valid <= 1'b0;
            // A request still in flight must have its response dropped.
            if ((state == WAIT || state == DRAIN) && !imem_resp_valid)
                state <= DRAIN;
            else
                state <= FETCH;
        end else begin
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            case (state)
                FETCH:    if (accept) state <= WAIT;
                WAIT:     if (imem_resp_valid) state <= stall ? BUFFERED : (accept ? WAIT : FETCH);
                BUFFERED: if (!stall) state <= FETCH;
                DRAIN:    if (imem_resp_valid) state <= FETCH;
                default:  state <= FETCH;
            endcase
            if (!stall) begin
                if (resp_now) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= req_pc;
                    if_id_instr <= imem_resp_data;
                end else if (state == BUFFERED && buf_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= buf_pc;
                    if_id_instr <= buf_instr;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end
        end
    end

    // A bubble must never look like a register read to the hazard unit.
    assign if_id_rs1 = if_id_valid ? if_id_instr[RS1_LSB +: 5] : 5'd0;
    assign if_id_rs2 = if_id_valid ? if_id_instr[RS2_LSB +: 5] : 5'd0;
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage with a 1- or 2-cycle instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int mem_lat = 1;
  logic        d1_v = 1'b0;
  logic [31:0] d1_a = 32'h0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .dbg_state       (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Instruction word per address: rs1 = rs2 = 15 at address 0.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h00F7_8013 ^ {a[21:0], 10'b0};
  endfunction

  // memory model: samples the handshake at the edge and responds mem_lat cycles later
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    logic        r;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    r   = rst;
    #1;
    if (r) begin
      imem_resp_valid = 1'b0;
      d1_v = 1'b0;
    end else if (mem_lat == 1) begin
      imem_resp_valid = acc;
      imem_resp_data  = instr_of(a);
    end else begin
      imem_resp_valid = d1_v;
      imem_resp_data  = instr_of(d1_a);
      d1_v = acc;
      d1_a = a;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // driver tasks: advance to just after the edge, then to the sampling point
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
    check({tag, "_pc"}, if_id_pc, pc);
    check({tag, "_instr"}, if_id_instr, instr_of(pc));
  endtask

  initial begin
    repeat (2) cyc();
    sample();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("rst_if_pc", if_id_pc, 32'h0);
    check("rst_if_instr", if_id_instr, 32'h0000_0013);
    check("rst_rs1", {27'b0, if_id_rs1}, 32'd0);
    check("rst_rs2", {27'b0, if_id_rs2}, 32'd0);

    // streaming from reset, 1-cycle memory
    cyc(); rst = 1'b0;                                        // c0
    sample();
    check("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c0_addr", imem_req_addr, 32'h0);
    cyc(); sample();                                          // c1
    check("c1_addr", imem_req_addr, 32'h4);
    check("c1_if_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(); sample();                                          // c2
    check_ifid("c2", 32'h0);
    check("c2_rs1", {27'b0, if_id_rs1}, 32'd15);
    check("c2_rs2", {27'b0, if_id_rs2}, 32'd15);
    check("c2_addr", imem_req_addr, 32'h8);
    cyc(); sample(); check_ifid("c3", 32'h4);                 // c3
    cyc(); sample(); check_ifid("c4", 32'h8);                 // c4
    cyc(); sample(); check_ifid("c5", 32'hC);                 // c5

    // stall for three cycles with 0x14 in flight
    cyc(); stall = 1'b1; sample();                            // c6
    check("c6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_ifid("c6", 32'h10);
    cyc(); sample();                                          // c7
    check("c7_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("c7_state", {30'b0, dbg_state}, 32'd2);
    check_ifid("c7", 32'h10);
    cyc(); sample();                                          // c8
    check("c8_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_ifid("c8", 32'h10);
    cyc(); stall = 1'b0; sample();                            // c9
    check("c9_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_ifid("c9", 32'h10);
    cyc(); sample();                                          // c10
    check_ifid("c10", 32'h14);
    check("c10_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c10_addr", imem_req_addr, 32'h18);
    cyc(); sample();                                          // c11
    check("c11_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c11_rs1", {27'b0, if_id_rs1}, 32'd0);
    check("c11_addr", imem_req_addr, 32'h1C);

    // memory not ready for four cycles
    cyc(); imem_req_ready = 1'b0; sample();                   // c12
    check_ifid("c12", 32'h18);
    check("c12_addr", imem_req_addr, 32'h20);
    cyc(); sample();                                          // c13
    check_ifid("c13", 32'h1C);
    check("c13_addr", imem_req_addr, 32'h20);
    cyc(); mem_lat = 2; sample();                             // c14
    check("c14_addr", imem_req_addr, 32'h20);
    check("c14_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c14_rs1", {27'b0, if_id_rs1}, 32'd0);
    check("c14_rs2", {27'b0, if_id_rs2}, 32'd0);
    cyc(); sample();                                          // c15
    check("c15_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c15_addr", imem_req_addr, 32'h20);
    cyc(); imem_req_ready = 1'b1; sample();                   // c16
    check("c16_addr", imem_req_addr, 32'h20);
    cyc(); sample();                                          // c17
    check("c17_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc(); sample();                                          // c18
    check("c18_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c18_addr", imem_req_addr, 32'h24);

    // redirect to 0x100 with 0x24 still outstanding
    cyc(); redirect = 1'b1; redirect_pc = 32'h100; sample();  // c19
    check("c19_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_ifid("c19", 32'h20);
    cyc(); redirect = 1'b0; sample();                         // c20
    check("c20_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c20_state", {30'b0, dbg_state}, 32'd3);
    check("c20_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc(); sample();                                          // c21
    check("c21_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c21_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c21_addr", imem_req_addr, 32'h100);
    cyc(); sample();                                          // c22
    check("c22_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cyc(); sample();                                          // c23
    check("c23_addr", imem_req_addr, 32'h104);

    // redirect and stall together: the flush wins
    cyc(); redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40; sample();  // c24
    check_ifid("c24", 32'h100);
    cyc(); redirect = 1'b0; stall = 1'b0; sample();           // c25
    check("c25_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c25_rs1", {27'b0, if_id_rs1}, 32'd0);
    check("c25_rs2", {27'b0, if_id_rs2}, 32'd0);
    check("c25_state", {30'b0, dbg_state}, 32'd3);
    cyc(); sample();                                          // c26
    check("c26_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c26_addr", imem_req_addr, 32'h40);
    cyc(); cyc(); cyc(); rst = 1'b1; sample();                // c29
    check("c29_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_ifid("c29", 32'h40);

    // after the reset pulse everything is back to reset values
    cyc(); rst = 1'b0; sample();                              // c30
    check("c30_if_valid", {31'b0, if_id_valid}, 32'd0);
    check("c30_if_pc", if_id_pc, 32'h0);
    check("c30_if_instr", if_id_instr, 32'h0000_0013);
    check("c30_state", {30'b0, dbg_state}, 32'd0);
    check("c30_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c30_addr", imem_req_addr, 32'h0);
    cyc(); cyc(); cyc(); sample();                            // c33
    check_ifid("c33", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
